// File: rtl/key_cmd_ctrl.sv
// Key gesture sequencer: classifies debounced key activity into short/long/repeat
// commands and issues each one on a req/ack handshake, flagging events that were dropped.
module key_cmd_ctrl #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int REPEAT_EN  = 1,
  parameter int TW         = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_value,
  input  logic       key_flag,
  output logic       cmd_req,
  output logic [1:0] cmd_mode,
  input  logic       cmd_ack,
  output logic       drop_flag,
  input  logic       drop_clr,
  output logic [1:0] key_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_LONG    = 2'd2;

  localparam logic [1:0] M_SHORT  = 2'd0;
  localparam logic [1:0] M_LONG   = 2'd1;
  localparam logic [1:0] M_REPEAT = 2'd2;

  localparam logic [TW-1:0] LONG_TERM = TW'(LONG_CNT - 1);
  localparam logic [TW-1:0] REP_TERM  = TW'(REPEAT_CNT - 1);

  logic          press_stb;
  logic          release_stb;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [TW-1:0] timer_inc;
  logic          ev_vld;
  logic [1:0]    ev_mode;
  logic          ev_accept;

  assign press_stb   = key_flag && !key_value;
  assign release_stb = key_flag && key_value;
  // Saturating increment keeps LONG_HELD stable forever when repeat is disabled.
  assign timer_inc   = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ev_vld    = 1'b0;
    ev_mode   = M_SHORT;
    case (state)
      S_IDLE: begin
        if (press_stb) begin
          state_nxt = S_PRESSED;
          timer_nxt = '0;
        end
      end
      S_PRESSED: begin
        timer_nxt = timer_inc;
        // Release wins over the long-press terminal in the same cycle.
        if (release_stb) begin
          ev_vld    = 1'b1;
          ev_mode   = M_SHORT;
          state_nxt = S_IDLE;
        end else if (timer == LONG_TERM) begin
          ev_vld    = 1'b1;
          ev_mode   = M_LONG;
          state_nxt = S_LONG;
          timer_nxt = '0;
        end
      end
      S_LONG: begin
        timer_nxt = timer_inc;
        if (release_stb) begin
          state_nxt = S_IDLE;
        end else if ((REPEAT_EN != 0) && (timer == REP_TERM)) begin
          ev_vld    = 1'b1;
          ev_mode   = M_REPEAT;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Handshake: cmd_req is held with cmd_mode stable until a cycle with
  // cmd_req && cmd_ack; that cycle may also load the next command directly.
  assign ev_accept = !cmd_req || cmd_ack;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_req   <= 1'b0;
      cmd_mode  <= M_SHORT;
      drop_flag <= 1'b0;
    end else begin
      if (ev_vld && ev_accept) begin
        cmd_req  <= 1'b1;
        cmd_mode <= ev_mode;
      end else if (cmd_req && cmd_ack) begin
        cmd_req <= 1'b0;
      end
      if (ev_vld && !ev_accept) begin
        drop_flag <= 1'b1;
      end else if (drop_clr) begin
        drop_flag <= 1'b0;
      end
    end
  end

  assign key_state = state;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl with LONG_CNT=20, REPEAT_CNT=8, REPEAT_EN=1.
// Inputs are driven and outputs sampled on the falling edge; "cycle t" is the rising edge after that.
module tb_key_cmd_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_value;
  logic       key_flag;
  logic       cmd_req;
  logic [1:0] cmd_mode;
  logic       cmd_ack;
  logic       drop_flag;
  logic       drop_clr;
  logic [1:0] key_state;

  int n_assert = 0;
  int n_fail   = 0;

  key_cmd_ctrl #(
    .LONG_CNT  (20),
    .REPEAT_CNT(8),
    .REPEAT_EN (1),
    .TW        (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_value(key_value),
    .key_flag (key_flag),
    .cmd_req  (cmd_req),
    .cmd_mode (cmd_mode),
    .cmd_ack  (cmd_ack),
    .drop_flag(drop_flag),
    .drop_clr (drop_clr),
    .key_state(key_state)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: tick moves to the next falling edge and clears all strobes.
  task automatic tick();
    @(negedge sys_clk);
    key_flag = 1'b0;
    cmd_ack  = 1'b0;
    drop_clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_key();
    key_flag  = 1'b1;
    key_value = 1'b0;
  endtask

  task automatic release_key();
    key_flag  = 1'b1;
    key_value = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_value = 1'b1;
    key_flag  = 1'b0;
    cmd_ack   = 1'b0;
    drop_clr  = 1'b0;
    #1;
    check("rst_req", cmd_req, 0);
    check("rst_mode", cmd_mode, 0);
    check("rst_drop", drop_flag, 0);
    check("rst_state", key_state, 0);
    ticks(2);
    sys_rst_n = 1'b1;
    ticks(2);

    // Short press: release at t0+10, ack at t0+13
    tick(); press_key();
    tick(); check("t1_state_pressed", key_state, 1);
    ticks(8);
    tick(); release_key();
    tick();
    check("t1_req_rise", cmd_req, 1);
    check("t1_mode_short", cmd_mode, 0);
    check("t1_state_idle", key_state, 0);
    tick(); check("t1_req_held", cmd_req, 1);
    tick(); cmd_ack = 1'b1; check("t1_req_at_ack", cmd_req, 1);
    tick(); check("t1_req_fall", cmd_req, 0);
    ticks(3);

    // Long hold with immediate ack, release at t0+40
    tick(); press_key();
    ticks(20);
    check("t2_no_req_t20", cmd_req, 0);
    check("t2_state_t20", key_state, 1);
    tick();
    check("t2_req_long", cmd_req, 1);
    check("t2_mode_long", cmd_mode, 1);
    check("t2_state_long", key_state, 2);
    cmd_ack = 1'b1;
    tick(); check("t2_req_fall1", cmd_req, 0);
    ticks(7);
    check("t2_req_rep1", cmd_req, 1);
    check("t2_mode_rep1", cmd_mode, 2);
    cmd_ack = 1'b1;
    tick(); check("t2_req_fall2", cmd_req, 0);
    ticks(7);
    check("t2_req_rep2", cmd_req, 1);
    check("t2_mode_rep2", cmd_mode, 2);
    cmd_ack = 1'b1;
    ticks(2);
    tick(); release_key();
    tick(); check("t2_state_idle", key_state, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); check("t2_no_more_req", cmd_req, 0);
    end

    // Long hold with ack withheld: drops and drop_clr
    tick(); press_key();
    ticks(21);
    check("t3_req_long", cmd_req, 1);
    check("t3_mode_long", cmd_mode, 1);
    check("t3_drop0", drop_flag, 0);
    ticks(8);
    check("t3_drop_set", drop_flag, 1);
    check("t3_req_kept", cmd_req, 1);
    check("t3_mode_kept", cmd_mode, 1);
    tick(); drop_clr = 1'b1;
    tick(); check("t3_drop_cleared", drop_flag, 0);
    ticks(5); drop_clr = 1'b1;
    tick();
    check("t3_drop_wins", drop_flag, 1);
    check("t3_mode_still_long", cmd_mode, 1);
    tick(); cmd_ack = 1'b1;
    tick(); check("t3_req_fall", cmd_req, 0);
    tick(); release_key();
    tick(); check("t3_state_idle", key_state, 0); drop_clr = 1'b1;
    tick(); check("t3_drop_clr2", drop_flag, 0);
    ticks(3);

    // Release exactly on the long-press terminal cycle
    tick(); press_key();
    ticks(20); release_key();
    check("t4_state_t20", key_state, 1);
    check("t4_no_req_t20", cmd_req, 0);
    tick();
    check("t4_req", cmd_req, 1);
    check("t4_mode_short", cmd_mode, 0);
    check("t4_state_idle", key_state, 0);
    cmd_ack = 1'b1;
    tick(); check("t4_req_fall", cmd_req, 0);
    ticks(5);
    check("t4_never_long", key_state, 0);
    check("t4_no_req_after", cmd_req, 0);

    // Reset while a long command is pending and drop_flag set
    tick(); press_key();
    ticks(21);
    check("t5_req_long", cmd_req, 1);
    check("t5_state_long", key_state, 2);
    ticks(8);
    check("t5_drop_set", drop_flag, 1);
    tick();
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_req", cmd_req, 0);
    check("t5_rst_mode", cmd_mode, 0);
    check("t5_rst_drop", drop_flag, 0);
    check("t5_rst_state", key_state, 0);
    tick(); sys_rst_n = 1'b1;
    tick(); release_key();
    tick();
    tick();
    check("t5_stray_release_req", cmd_req, 0);
    check("t5_stray_release_state", key_state, 0);

    // Stray release in IDLE, second press in PRESSED must not restart timer
    tick(); release_key();
    tick();
    check("t6_idle_release_req", cmd_req, 0);
    check("t6_idle_release_state", key_state, 0);
    tick(); press_key();
    ticks(5); press_key();
    tick(); check("t6_state_after_repress", key_state, 1);
    ticks(14);
    check("t6_no_req_t20", cmd_req, 0);
    check("t6_state_t20", key_state, 1);
    tick();
    check("t6_req_long_t21", cmd_req, 1);
    check("t6_mode_long_t21", cmd_mode, 1);
    check("t6_state_long_t21", key_state, 2);
    cmd_ack = 1'b1;
    tick(); release_key();
    tick();
    check("t6_req_fall", cmd_req, 0);
    check("t6_state_idle", key_state, 0);
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
